stream_mux: RTL and testbench

STREAM_MUX -- requirements
Module: stream_mux

---
 rtl/stream_mux.sv | 118 +++++++++++
 tb/tb_stream_mux.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// stream_mux: CH-input to 1-output stream multiplexer with a one-deep
// registered output stage. Arbitration is round-robin (mode=0) or a fixed
// channel select (mode=1). Optional packet locking is enabled with the
// STREAM_MUX_LOCK_EN macro, which adds in_last/out_last and holds the grant
// on a channel until the beat flagged with in_last goes through.
module stream_mux #(
  parameter int N  = 8,
  parameter int CH = 4,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [CW-1:0]    sel,
  input  logic [CH-1:0]    in_valid,
  input  logic [CH*N-1:0]  in_data,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [CH-1:0]    in_last,
  output logic             out_last,
`endif
  output logic [CH-1:0]    in_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  output logic [CW-1:0]    out_ch,
  input  logic             out_ready
);

  logic [CH-1:0][N-1:0] din;
  logic [CW-1:0]        last;
  logic [CW-1:0]        rr_g, g;
  logic                 rr_v, fx_v, gv;
  logic                 load, xfer;

  assign din  = in_data;
  assign load = ~out_valid | out_ready;

  // round-robin: scan downward from the farthest candidate so the nearest
  // valid channel after `last` is the one left standing
  always_comb begin
    logic [CW:0]   sum;
    logic [CW-1:0] idx;
    rr_g = '0;
    rr_v = 1'b0;
    sum  = '0;
    idx  = '0;
    for (int k = CH; k >= 1; k--) begin
      sum = {1'b0, last} + (CW+1)'(k);
      idx = (sum >= (CW+1)'(CH)) ? CW'(sum - (CW+1)'(CH)) : CW'(sum);
      if (in_valid[idx]) begin
        rr_g = idx;
        rr_v = 1'b1;
      end
    end
  end

  // fixed select: out-of-range sel values never grant
  assign fx_v = ({1'b0, sel} < (CW+1)'(CH)) & in_valid[sel];

`ifdef STREAM_MUX_LOCK_EN
  logic locked;
`endif

  // grant selection; an open packet overrides both arbitration modes
  always_comb begin
    g  = rr_g;
    gv = rr_v;
    if (mode) begin
      g  = sel;
      gv = fx_v;
    end
`ifdef STREAM_MUX_LOCK_EN
    // last always holds the locked channel since it tracks every transfer
    if (locked) begin
      g  = last;
      gv = in_valid[last];
    end
`endif
  end

  assign xfer = load & gv & ~reset;

  // one-hot ready toward the granted channel only
  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[g] = 1'b1;
  end

  // output register and arbitration pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= CW'(CH-1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= din[g];
      out_ch    <= g;
      last      <= g;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  // packet lock: a beat without in_last keeps the grant on its channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked   <= 1'b0;
      out_last <= 1'b0;
    end else if (xfer) begin
      locked   <= ~in_last[g];
      out_last <= in_last[g];
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: a transaction-level model (pointer, output beat,
// lock flag) checked against the DUT every cycle on the falling edge, plus
// directed scenarios with literal expectations. A second CH=3 instance covers
// non-power-of-two wrap and out-of-range sel.
module tb_stream_mux;
  localparam int N  = 8;
  localparam int CH = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode = 1'b0;
  logic out_ready = 1'b0;
  logic [CW-1:0]   sel = '0;
  logic [CH-1:0]   in_valid = '0;
  logic [CH*N-1:0] in_data = '0;
  logic [CH-1:0]   in_ready;
  logic            out_valid;
  logic [N-1:0]    out_data;
  logic [CW-1:0]   out_ch;
`ifdef STREAM_MUX_LOCK_EN
  logic [CH-1:0]   in_last = '1;
  logic            out_last;
  logic [2:0]      il3 = '1;
  logic            ol3;
`endif

  // CH=3 instance signals
  logic       mode3 = 1'b0, or3 = 1'b1;
  logic [1:0] sel3 = '0;
  logic [2:0] iv3 = '0;
  logic [23:0] id3 = '0;
  logic [2:0] ir3;
  logic       ov3;
  logic [7:0] od3;
  logic [1:0] oc3;

  stream_mux #(.N(N), .CH(CH)) u_dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_ready(out_ready)
  );

  stream_mux #(.N(8), .CH(3)) u_dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
    .in_valid(iv3), .in_data(id3),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(il3), .out_last(ol3),
`endif
    .in_ready(ir3), .out_valid(ov3), .out_data(od3),
    .out_ch(oc3), .out_ready(or3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_ov;
  logic [N-1:0] m_od;
  int         m_oc, m_last;
  bit         m_lock, m_ol;

  function automatic void model_reset();
    m_ov = 0; m_od = '0; m_oc = 0; m_last = CH-1; m_lock = 0; m_ol = 0;
  endfunction

  function automatic void m_grant(output int g, output bit gv);
    g = 0; gv = 0;
    if (m_lock) begin
      g = m_last; gv = in_valid[g];
    end else if (mode) begin
      g = int'(sel);
      if (g < CH) gv = in_valid[g];
    end else begin
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (m_last + k) % CH;
        if (!gv && in_valid[c]) begin g = c; gv = 1; end
      end
    end
  endfunction

  // model advances on every clock edge outside reset
  always @(posedge clk) begin
    int g; bit gv;
    if (!reset) begin
      m_grant(g, gv);
      if (!m_ov || out_ready) begin
        if (gv) begin
          m_ov = 1; m_od = in_data[g*N +: N]; m_oc = g; m_last = g;
`ifdef STREAM_MUX_LOCK_EN
          m_ol = in_last[g]; m_lock = !in_last[g];
`endif
        end else begin
          m_ov = 0;
        end
      end
    end
  end

  // compare process: DUT vs model, once per cycle away from the active edge
  always @(negedge clk) begin
    int g; bit gv; int er;
    if (chk_en) begin
      m_grant(g, gv);
      er = 0;
      if (!reset && (!m_ov || out_ready) && gv) er = 1 << g;
      chk("m_in_ready", int'(in_ready), er);
      chk("m_out_valid", int'(out_valid), int'(m_ov));
      chk("m_out_data", int'(out_data), int'(m_od));
      chk("m_out_ch", int'(out_ch), m_oc);
`ifdef STREAM_MUX_LOCK_EN
      chk("m_out_last", int'(out_last), int'(m_ol));
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // leaves reset asserted; caller sets inputs then drops reset
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; model_reset();
    tick(); tick();
  endtask

  initial begin
    model_reset();
    in_valid = 4'hF; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk_en = 1'b1;
    tick(); tick();

    // round-robin full load: 0,1,2,3,0
    mode = 0; in_data = {8'h44, 8'h33, 8'h22, 8'h11}; reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_seq_ch", int'(out_ch), k % 4);
      chk("rr_seq_valid", int'(out_valid), 1);
    end
    chk("rr_seq_data", int'(out_data), 8'h11);

    // reset between edges mid-stream
    @(posedge clk); #3;
    reset = 1'b1; model_reset();
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_ch", int'(out_ch), 0);
    chk("async_rst_ready", int'(in_ready), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ch", int'(out_ch), 0);
    chk("post_rst_valid", int'(out_valid), 1);

    // wrap-around with channels 0 and 3
    do_reset();
    in_valid = 4'b1001; reset = 1'b0;
    tick(); chk("wrap_0", int'(out_ch), 0);
    tick(); chk("wrap_1", int'(out_ch), 3);
    tick(); chk("wrap_2", int'(out_ch), 0);
    tick(); chk("wrap_3", int'(out_ch), 3);

    // fixed select
    mode = 1; sel = 2; in_data = {8'h00, 8'hA5, 8'h00, 8'h00}; in_valid = 4'b0100;
    #1; chk("fix_ready", int'(in_ready), 4'b0100);
    tick();
    chk("fix_data", int'(out_data), 8'hA5);
    chk("fix_ch", int'(out_ch), 2);
    sel = 3; #1;
    chk("fix_sel_novalid", int'(in_ready), 0);

    // backpressure stall for 3 cycles, then release
    do_reset();
    mode = 0; in_valid = 4'b0001; in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b0; reset = 1'b0;
    tick();
    in_valid = 4'hF;
    for (int r = 0; r < 3; r++) begin
      #1;
      chk("stall_ready", int'(in_ready), 0);
      chk("stall_data", int'(out_data), 8'h11);
      chk("stall_valid", int'(out_valid), 1);
      tick();
    end
    in_valid = 4'b0010; out_ready = 1'b1; #1;
    chk("unstall_ready", int'(in_ready), 4'b0010);
    tick();
    chk("unstall_data", int'(out_data), 8'h22);
    chk("unstall_ch", int'(out_ch), 1);

    // CH=3 instance: wrap at 2 -> 0, and sel=3 grants nothing
    in_valid = '0;
    do_reset();
    mode3 = 0; iv3 = 3'b101; or3 = 1'b1; id3 = {8'hC3, 8'hB3, 8'hA3}; reset = 1'b0;
    tick(); chk("ch3_wrap_a", int'(oc3), 0); chk("ch3_data_a", int'(od3), 8'hA3);
    tick(); chk("ch3_wrap_b", int'(oc3), 2); chk("ch3_data_b", int'(od3), 8'hC3);
    tick(); chk("ch3_wrap_c", int'(oc3), 0);
    mode3 = 1; sel3 = 3; iv3 = 3'b111; #1;
    chk("ch3_sel_oob", int'(ir3), 0);
    sel3 = 2; #1;
    chk("ch3_sel_2", int'(ir3), 3'b100);
    iv3 = '0;

`ifdef STREAM_MUX_LOCK_EN
    // ch1 three-beat packet holds the grant against ch2 and a mode switch
    do_reset();
    mode = 0; in_valid = 4'b0110; in_last = 4'b0000; reset = 1'b0;
    tick(); chk("lock_b1", int'(out_ch), 1); chk("lock_l1", int'(out_last), 0);
    mode = 1; sel = 2;
    tick(); chk("lock_b2", int'(out_ch), 1); chk("lock_l2", int'(out_last), 0);
    in_last = 4'b0010;
    tick(); chk("lock_b3", int'(out_ch), 1); chk("lock_l3", int'(out_last), 1);
    in_last = '1;
    tick(); chk("lock_after", int'(out_ch), 2);
    mode = 0;
`endif

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      mode      = ($urandom_range(0, 3) == 0);
      sel       = CW'($urandom);
      in_valid  = CH'($urandom);
      in_data   = (CH*N)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_LOCK_EN
      in_last   = CH'($urandom);
`endif
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1; model_reset();
        tick();
        reset = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
